// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl: front-panel run/halt/step controller for a slow demo CPU.
// Two raw buttons are synchronised and debounced into one-cycle press
// pulses; a four-state FSM turns those presses, a tick divider and a PC
// breakpoint comparator into a single-cycle cpu_en per instruction.
module cpu_run_ctrl #(
  parameter int unsigned TICK_DIV        = 1000000,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        btn_run,
  input  logic        btn_step,
  input  logic        bp_enable,
  input  logic [15:0] bp_addr,
  input  logic [15:0] pc,
  output logic        cpu_en,
  output logic [1:0]  state,
  output logic        halted,
  output logic [15:0] instr_count
);

  // Wide enough for counts up to 2^24 on both the tick and debounce paths.
  localparam int unsigned CW = 25;
  localparam logic [CW-1:0] TICK_LAST = CW'(TICK_DIV - 1);
  localparam logic [CW-1:0] DB_LAST   = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_HALT  = 2'b00,
    ST_RUN   = 2'b01,
    ST_STEP  = 2'b10,
    ST_BREAK = 2'b11
  } state_t;

  // Index 0 is the run button, index 1 the step button.
  logic [1:0] btn_raw;
  logic [1:0] press;

  assign btn_raw = {btn_step, btn_run};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_btn
      logic          sync1_q, sync1_d;
      logic          sync2_q, sync2_d;
      logic          level_q, level_d;
      logic          level_prev_q, level_prev_d;
      logic [CW-1:0] cnt_q, cnt_d;

      // Debounce: the accepted level follows the synchronised level only
      // after DEBOUNCE_CYCLES consecutive disagreeing samples.
      always_comb begin
        sync1_d      = btn_raw[gi];
        sync2_d      = sync1_q;
        level_prev_d = level_q;
        level_d      = level_q;
        cnt_d        = '0;
        if (sync2_q != level_q) begin
          if (cnt_q == DB_LAST) begin
            level_d = sync2_q;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end

      // Synchroniser, debounce counter and accepted-level registers.
      always_ff @(posedge clk) begin
        if (reset) begin
          sync1_q      <= 1'b0;
          sync2_q      <= 1'b0;
          level_q      <= 1'b0;
          level_prev_q <= 1'b0;
          cnt_q        <= '0;
        end else begin
          sync1_q      <= sync1_d;
          sync2_q      <= sync2_d;
          level_q      <= level_d;
          level_prev_q <= level_prev_d;
          cnt_q        <= cnt_d;
        end
      end

      // One pulse on the cycle after the accepted level rises; release is silent.
      assign press[gi] = level_q & ~level_prev_q;
    end
  endgenerate

  logic run_press;
  logic step_press;

  assign run_press  = press[0];
  assign step_press = press[1];

  state_t        state_q, state_d;
  logic [CW-1:0] tick_q, tick_d;
  logic          skip_q, skip_d;
  logic [15:0]   instr_count_q, instr_count_d;
  logic          bp_match;
  logic          cpu_en_c;

  // Next-state and instruction enable; a run press or breakpoint in RUN
  // wins over the tick so the enable never overlaps a stop.
  always_comb begin
    state_d  = state_q;
    cpu_en_c = 1'b0;
    bp_match = (state_q == ST_RUN) && bp_enable && (pc == bp_addr) && !skip_q;
    case (state_q)
      ST_HALT: begin
        if (run_press) begin
          state_d = ST_RUN;
        end else if (step_press) begin
          state_d = ST_STEP;
        end
      end
      ST_RUN: begin
        if (run_press) begin
          state_d = ST_HALT;
        end else if (bp_match) begin
          state_d = ST_BREAK;
        end else if (tick_q == TICK_LAST) begin
          cpu_en_c = 1'b1;
        end
      end
      ST_STEP: begin
        cpu_en_c = 1'b1;
        state_d  = ST_HALT;
      end
      ST_BREAK: begin
        if (run_press) begin
          state_d = ST_RUN;
        end else if (step_press) begin
          state_d = ST_STEP;
        end
      end
      default: state_d = ST_HALT;
    endcase
  end

  // Tick divider, breakpoint-skip flag and instruction counter updates.
  always_comb begin
    tick_d        = '0;
    skip_d        = 1'b0;
    instr_count_d = instr_count_q + 16'(cpu_en_c);
    if (state_q == ST_RUN && state_d == ST_RUN) begin
      tick_d = (tick_q == TICK_LAST) ? '0 : tick_q + CW'(1);
    end
    // Resuming from BREAK must let the breakpoint instruction execute once.
    if (state_q == ST_BREAK && state_d == ST_RUN) begin
      skip_d = 1'b1;
    end else if (state_q == ST_RUN && state_d == ST_RUN && !cpu_en_c) begin
      skip_d = skip_q;
    end
  end

  // Controller state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_HALT;
      tick_q        <= '0;
      skip_q        <= 1'b0;
      instr_count_q <= '0;
    end else begin
      state_q       <= state_d;
      tick_q        <= tick_d;
      skip_q        <= skip_d;
      instr_count_q <= instr_count_d;
    end
  end

  assign cpu_en      = cpu_en_c;
  assign state       = state_q;
  assign halted      = (state_q == ST_HALT) || (state_q == ST_BREAK);
  assign instr_count = instr_count_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Testbench for cpu_run_ctrl with TICK_DIV=4, DEBOUNCE_CYCLES=3.
// Directed scenario tasks plus a randomized run against a behavioural model
// that treats debouncing as a sliding window over raw button history.
module tb_cpu_run_ctrl;
  localparam int TD = 4;
  localparam int DB = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        btn_run;
  logic        btn_step;
  logic        bp_enable;
  logic [15:0] bp_addr;
  logic [15:0] pc;
  logic        cpu_en;
  logic [1:0]  state;
  logic        halted;
  logic [15:0] instr_count;

  int n_tests = 0;
  int n_fail  = 0;

  cpu_run_ctrl #(.TICK_DIV(TD), .DEBOUNCE_CYCLES(DB)) dut (
    .clk         (clk),
    .reset       (reset),
    .btn_run     (btn_run),
    .btn_step    (btn_step),
    .bp_enable   (bp_enable),
    .bp_addr     (bp_addr),
    .pc          (pc),
    .cpu_en      (cpu_en),
    .state       (state),
    .halted      (halted),
    .instr_count (instr_count)
  );

  always #5 clk = ~clk;

  // Behavioural model: mode 0 HALT, 1 RUN, 2 STEP, 3 BREAK.
  int          m_mode  = 0;
  int          m_phase = 0;   // cycles spent in RUN since entry
  bit          m_skip  = 0;
  logic [15:0] m_count = '0;
  bit          m_db    [2];
  bit          m_press [2];
  bit          m_hist  [2][0:DB+1];  // raw samples, newest first

  function automatic bit model_match();
    return (m_mode == 1) && bp_enable && (pc == bp_addr) && !m_skip;
  endfunction

  function automatic bit model_en();
    if (m_mode == 2) return 1'b1;
    return (m_mode == 1) && ((m_phase % TD) == TD - 1) && !m_press[0] && !model_match();
  endfunction

  task automatic model_edge();
    bit rp, sp, en, mt, all_diff;
    bit raw [2];
    int nxt;
    if (reset) begin
      m_mode = 0; m_phase = 0; m_skip = 0; m_count = '0;
      for (int b = 0; b < 2; b++) begin
        m_db[b] = 0; m_press[b] = 0;
        for (int i = 0; i <= DB + 1; i++) m_hist[b][i] = 0;
      end
      return;
    end
    rp = m_press[0]; sp = m_press[1]; en = model_en(); mt = model_match();
    nxt = m_mode;
    case (m_mode)
      0: if (rp) nxt = 1; else if (sp) nxt = 2;
      1: if (rp) nxt = 0; else if (mt) nxt = 3;
      2: nxt = 0;
      default: if (rp) nxt = 1; else if (sp) nxt = 2;
    endcase
    m_count = m_count + 16'(en);
    if (nxt == 1 && m_mode != 1) m_phase = 0;
    else if (m_mode == 1) m_phase++;
    if (m_mode == 3 && nxt == 1) m_skip = 1;
    else if (en || nxt != 1) m_skip = 0;
    m_mode = nxt;
    raw[0] = btn_run; raw[1] = btn_step;
    for (int b = 0; b < 2; b++) begin
      // Level accepted when the synchronised samples (two edges old) of the
      // last DB cycles all disagree with the current level.
      all_diff = 1;
      for (int i = 1; i <= DB; i++) if (m_hist[b][i] == m_db[b]) all_diff = 0;
      m_press[b] = 0;
      if (all_diff) begin
        m_db[b] = ~m_db[b];
        m_press[b] = m_db[b];
      end
      for (int i = DB + 1; i >= 1; i--) m_hist[b][i] = m_hist[b][i-1];
      m_hist[b][0] = raw[b];
    end
  endtask

  // Advance one clock: model and DUT both update on this edge.
  task automatic adv();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) adv();
    @(negedge clk);
    n_tests++;
    if (cpu_en !== 1'b0 || state !== 2'b00 || halted !== 1'b1 || instr_count !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_state: en=%b state=%b halted=%b count=%h, want 0 00 1 0000",
               cpu_en, state, halted, instr_count);
    end
    adv();
    reset = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      n_tests++;
      if (cpu_en !== 1'b0 || state !== 2'b00 || halted !== 1'b1 || instr_count !== 16'h0) begin
        n_fail++;
        $display("FAIL idle[%0d]: en=%b state=%b halted=%b count=%h, want 0 00 1 0000",
                 i, cpu_en, state, halted, instr_count);
      end
      adv();
    end
  endtask

  task automatic test_run();
    int waited = 0;
    int pulses = 0;
    int last = -1;
    int gap_bad = 0;
    btn_run = 1'b1;
    while (state !== 2'b01 && waited < 10) begin adv(); waited++; end
    n_tests++;
    if (state !== 2'b01 || waited > 6) begin
      n_fail++;
      $display("FAIL run_entry: state=%b after %0d cycles, want 01 within 6", state, waited);
    end
    for (int cyc = 0; cyc < 200 && pulses < 20; cyc++) begin
      if (waited + cyc >= 10) btn_run = 1'b0;
      @(negedge clk);
      if (cpu_en === 1'b1) begin
        if (last >= 0 && cyc - last != TD) gap_bad++;
        last = cyc;
        pulses++;
      end
      adv();
    end
    btn_run = 1'b0;
    n_tests++;
    if (pulses != 20 || gap_bad != 0) begin
      n_fail++;
      $display("FAIL run_pulses: got %0d pulses with %0d bad gaps, want 20 with 0", pulses, gap_bad);
    end
    n_tests++;
    if (instr_count !== 16'd20) begin
      n_fail++;
      $display("FAIL run_count: got %0d want 20", instr_count);
    end
    repeat (6) adv();
    btn_run = 1'b1;
    adv();
    btn_run = 1'b0;
    repeat (12) adv();
    n_tests++;
    if (state !== 2'b01 || instr_count !== m_count) begin
      n_fail++;
      $display("FAIL run_glitch: state=%b count=%h, want 01 count=%h", state, instr_count, m_count);
    end
  endtask

  task automatic test_step();
    logic [15:0] exp;
    int en_cnt = 0;
    int st_cnt = 0;
    int bad_pair = 0;
    btn_run = 1'b1; repeat (6) adv(); btn_run = 1'b0; repeat (10) adv();
    n_tests++;
    if (state !== 2'b00) begin
      n_fail++;
      $display("FAIL halt_from_run: state=%b want 00", state);
    end
    exp = m_count + 16'd1;
    for (int i = 0; i < 50; i++) begin
      btn_step = (i < 40);
      @(negedge clk);
      if (cpu_en === 1'b1) en_cnt++;
      if (state === 2'b10) st_cnt++;
      if ((state === 2'b10) != (cpu_en === 1'b1)) bad_pair++;
      adv();
    end
    n_tests++;
    if (en_cnt != 1 || st_cnt != 1 || bad_pair != 0) begin
      n_fail++;
      $display("FAIL step_once: en=%0d step_cycles=%0d bad=%0d, want 1 1 0", en_cnt, st_cnt, bad_pair);
    end
    n_tests++;
    if (instr_count !== exp || state !== 2'b00) begin
      n_fail++;
      $display("FAIL step_count: count=%h state=%b, want %h 00", instr_count, state, exp);
    end
  endtask

  task automatic test_breakpoint();
    int w = 0;
    int bad = 0;
    bit found = 0;
    bp_enable = 1'b1; bp_addr = 16'h0006; pc = 16'h0000;
    btn_run = 1'b1;
    while (state !== 2'b01 && w < 10) begin adv(); w++; end
    btn_run = 1'b0;
    repeat (7) adv();
    pc = 16'h0006;
    @(negedge clk);
    n_tests++;
    if (cpu_en !== 1'b0 || state !== 2'b01) begin
      n_fail++;
      $display("FAIL bp_cycle: en=%b state=%b, want 0 01", cpu_en, state);
    end
    adv();
    n_tests++;
    if (state !== 2'b11 || halted !== 1'b1 || cpu_en !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_break: state=%b halted=%b en=%b, want 11 1 0", state, halted, cpu_en);
    end
    repeat (3) adv();
    btn_run = 1'b1; w = 0;
    while (state !== 2'b01 && w < 10) begin adv(); w++; end
    btn_run = 1'b0;
    n_tests++;
    if (state !== 2'b01) begin
      n_fail++;
      $display("FAIL bp_resume: state=%b want 01", state);
    end
    w = 0;
    while (!found && w < TD + 2) begin
      @(negedge clk);
      if (cpu_en === 1'b1) found = 1;
      else if (state !== 2'b01) bad++;
      adv();
      w++;
    end
    n_tests++;
    if (!found || bad != 0) begin
      n_fail++;
      $display("FAIL bp_resume_exec: en_seen=%0d bad=%0d, want 1 0", found, bad);
    end
    @(negedge clk);
    n_tests++;
    if (cpu_en !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_rematch_en: en=%b want 0", cpu_en);
    end
    adv();
    n_tests++;
    if (state !== 2'b11) begin
      n_fail++;
      $display("FAIL bp_rebreak: state=%b want 11", state);
    end
    btn_step = 1'b1; w = 0;
    while (state !== 2'b10 && w < 10) begin adv(); w++; end
    n_tests++;
    if (state !== 2'b10 || cpu_en !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_step: state=%b en=%b, want 10 1", state, cpu_en);
    end
    adv();
    n_tests++;
    if (state !== 2'b00 || instr_count !== m_count) begin
      n_fail++;
      $display("FAIL bp_step_halt: state=%b count=%h, want 00 %h", state, instr_count, m_count);
    end
    btn_step = 1'b0; bp_enable = 1'b0; pc = 16'h0000;
    repeat (10) adv();
  endtask

  task automatic test_simultaneous();
    int w = 0;
    btn_run = 1'b1; btn_step = 1'b1;
    while (state === 2'b00 && w < 10) begin adv(); w++; end
    n_tests++;
    if (state !== 2'b01) begin
      n_fail++;
      $display("FAIL both_press: state=%b want 01", state);
    end
    btn_run = 1'b0; btn_step = 1'b0;
    repeat (10) adv();
    n_tests++;
    if (state !== 2'b01) begin
      n_fail++;
      $display("FAIL both_release: state=%b want 01", state);
    end
    btn_run = 1'b1; repeat (6) adv(); btn_run = 1'b0; repeat (10) adv();
    n_tests++;
    if (state !== 2'b00) begin
      n_fail++;
      $display("FAIL both_halt: state=%b want 00", state);
    end
  endtask

  task automatic test_wrap();
    @(negedge clk);
    dut.instr_count_q = 16'hFFFF;
    m_count = 16'hFFFF;
    adv();
    btn_step = 1'b1; repeat (6) adv(); btn_step = 1'b0; repeat (10) adv();
    n_tests++;
    if (instr_count !== 16'h0000 || state !== 2'b00) begin
      n_fail++;
      $display("FAIL wrap: count=%h state=%b, want 0000 00", instr_count, state);
    end
  endtask

  task automatic test_reset_mid();
    int w = 0;
    int first = 0;
    bit found = 0;
    btn_run = 1'b1;
    while (state !== 2'b01 && w < 10) begin adv(); w++; end
    btn_run = 1'b0;
    repeat (6) adv();
    w = 0;
    while (!found && w < TD + 2) begin
      @(negedge clk);
      if (cpu_en === 1'b1) found = 1;
      else begin adv(); w++; end
    end
    n_tests++;
    if (!found) begin
      n_fail++;
      $display("FAIL rst_tick_seen: no cpu_en within %0d cycles", TD + 2);
    end
    reset = 1'b1; btn_run = 1'b1;
    adv();
    n_tests++;
    if (cpu_en !== 1'b0 || state !== 2'b00 || halted !== 1'b1 || instr_count !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_in_run: en=%b state=%b halted=%b count=%h, want 0 00 1 0000",
               cpu_en, state, halted, instr_count);
    end
    adv();
    reset = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      adv();
      if (state === 2'b01 && first == 0) first = k;
    end
    n_tests++;
    if (first < 5 || first > 7) begin
      n_fail++;
      $display("FAIL held_through_reset: RUN reached after %0d cycles, want 5..7", first);
    end
    btn_run = 1'b0; repeat (10) adv();
    btn_run = 1'b1; repeat (6) adv(); btn_run = 1'b0; repeat (10) adv();
    btn_step = 1'b1; w = 0;
    while (state !== 2'b10 && w < 10) begin adv(); w++; end
    reset = 1'b1; btn_step = 1'b0;
    adv();
    n_tests++;
    if (cpu_en !== 1'b0 || state !== 2'b00 || instr_count !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_in_step: en=%b state=%b count=%h, want 0 00 0000", cpu_en, state, instr_count);
    end
    reset = 1'b0;
    repeat (10) adv();
    n_tests++;
    if (cpu_en !== 1'b0 || state !== 2'b00 || instr_count !== 16'h0) begin
      n_fail++;
      $display("FAIL post_reset_quiet: en=%b state=%b count=%h, want 0 00 0000", cpu_en, state, instr_count);
    end
  endtask

  task automatic test_random();
    int rh = 0;
    int sh = 0;
    int shown = 0;
    bit e_h;
    reset = 1'b1; adv(); adv(); reset = 1'b0;
    bp_addr = 16'h0006; bp_enable = 1'b1;
    for (int c = 0; c < 2500; c++) begin
      if (rh > 0) rh--; else if ($urandom_range(0, 29) == 0) rh = $urandom_range(1, 14);
      if (sh > 0) sh--; else if ($urandom_range(0, 39) == 0) sh = $urandom_range(1, 14);
      btn_run  = (rh > 0);
      btn_step = (sh > 0);
      if ($urandom_range(0, 99) == 0) bp_enable = ~bp_enable;
      if ($urandom_range(0, 3) == 0) pc = 16'($urandom_range(0, 9));
      reset = ($urandom_range(0, 399) == 0);
      @(negedge clk);
      e_h = (m_mode == 0) || (m_mode == 3);
      n_tests++;
      if (cpu_en !== model_en() || state !== m_mode[1:0] || halted !== e_h || instr_count !== m_count) begin
        n_fail++;
        if (shown < 10) begin
          $display("FAIL random[%0d]: en=%b state=%b halted=%b count=%h, want %b %b %b %h",
                   c, cpu_en, state, halted, instr_count, model_en(), m_mode[1:0], e_h, m_count);
        end
        shown++;
      end
      adv();
    end
    reset = 1'b0; btn_run = 1'b0; btn_step = 1'b0;
  endtask

  initial begin
    reset = 1'b1; btn_run = 1'b0; btn_step = 1'b0;
    bp_enable = 1'b0; bp_addr = 16'h0000; pc = 16'h0000;
    test_reset();
    test_run();
    test_step();
    test_breakpoint();
    test_simultaneous();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Hard stop if the sequence above ever stalls.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", n_tests, n_fail);
    $fatal(1);
  end

endmodule
